// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared widths, requester ids and read-tag type for the BRAM port arbiter
package bram_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef logic req_id_t;

    localparam req_id_t REQ_CAPTURE = 1'b0;
    localparam req_id_t REQ_READOUT = 1'b1;

    // Tag carried alongside each BRAM access so read data finds its way home.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    function automatic rd_tag_t make_tag(input logic valid, input req_id_t id);
        rd_tag_t t;
        t.valid = valid;
        t.id    = id;
        return t;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop single-bit synchroniser
//
// Ports:
//   clk   destination clock
//   rst_n asynchronous active-low reset, forces both flops to RESET_VAL
//   d     asynchronous input
//   q     synchronised output, two destination edges behind d
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin two-requester arbiter for a single BRAM port
//
// Ports:
//   clk_100mhz, reset      clock and asynchronous active-low reset
//   locked                 MMCM lock (asynchronous); no grants until synchronised high
//   reqN_valid/ready       request handshake, N = 0 capture (writes), 1 readout
//   reqN_we/addr/wdata     request payload, held stable while valid & !ready
//   rspN_valid/rdata       one-cycle read response to the issuing requester
//   mem_en/we/addr/wdata   registered BRAM command, mem_rdata BRAM read data
//   busy                   command on the port or any read still in flight
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 2
) (
    input  logic              clk_100mhz,
    input  logic              reset,
    input  logic              locked,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    logic    lock_s;
    req_id_t ptr;           // requester favoured when both are valid
    logic    grant0;
    logic    grant1;
    rd_tag_t issue_tag;     // tag for the command currently on mem_*
    rd_tag_t pipe [0:RD_LAT];
    rd_tag_t emerge;

    sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
        .clk   (clk_100mhz),
        .rst_n (reset),
        .d     (locked),
        .q     (lock_s)
    );

    always_comb begin
        grant0 = lock_s & req0_valid & (~req1_valid | (ptr == REQ_CAPTURE));
        grant1 = lock_s & req1_valid & (~req0_valid | (ptr == REQ_READOUT));
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            ptr <= REQ_CAPTURE;
        end else if (grant0) begin
            ptr <= REQ_READOUT;
        end else if (grant1) begin
            ptr <= REQ_CAPTURE;
        end
    end

    // Issue register: one-cycle command per grant; address/data hold otherwise.
    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            issue_tag <= '0;
        end else begin
            mem_en <= grant0 | grant1;
            if (grant0) begin
                mem_we    <= req0_we;
                mem_addr  <= req0_addr;
                mem_wdata <= req0_wdata;
                issue_tag <= make_tag(~req0_we, REQ_CAPTURE);
            end else if (grant1) begin
                mem_we    <= req1_we;
                mem_addr  <= req1_addr;
                mem_wdata <= req1_wdata;
                issue_tag <= make_tag(~req1_we, REQ_READOUT);
            end else begin
                mem_we    <= 1'b0;
                issue_tag <= '0;
            end
        end
    end

    // The BRAM samples the command one edge after issue and presents data
    // RD_LAT edges later, so the tag needs RD_LAT+1 stages behind the issue
    // register to line up with the edge that captures mem_rdata.
    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= issue_tag;
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign emerge = pipe[RD_LAT];

    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= emerge.valid & (emerge.id == REQ_CAPTURE);
            rsp1_valid <= emerge.valid & (emerge.id == REQ_READOUT);
            if (emerge.valid && emerge.id == REQ_CAPTURE) begin
                rsp0_rdata <= mem_rdata;
            end
            if (emerge.valid && emerge.id == REQ_READOUT) begin
                rsp1_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        busy = mem_en;
        for (int i = 0; i <= RD_LAT; i++) begin
            busy = busy | pipe[i].valid;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed self-checking bench for bram_port_arbiter
module tb_bram_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic              clk_100mhz = 1'b0;
    logic              reset;
    logic              locked;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic              req0_we, req1_we;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_wdata, req1_wdata;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .locked     (locked),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    // BRAM model: command sampled one edge after issue, data out RD_LAT edges later.
    bit          init_done;
    logic [31:0] mem [0:1023];
    logic [31:0] rd_pipe [0:RD_LAT];

    always @(posedge clk_100mhz) begin
        if (!init_done) begin
            mem[5]    <= 32'hDEAD_BEEF;
            init_done <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i <= RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign mem_rdata = rd_pipe[RD_LAT];

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int  wi;
    int  ri;
    logic exp_rsp;

    initial begin
        reset      = 1'b0;
        locked     = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_we    = 1'b0;
        req1_we    = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        req0_wdata = '0;
        req1_wdata = '0;
        repeat (3) tick();

        // Reset state
        req0_valid = 1'b1;
        req0_we    = 1'b1;
        req0_addr  = 10'h100;
        req0_wdata = 32'h0BAD_0BAD;
        #1;
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp1_rdata", rsp1_rdata, 0);

        // Lock gating
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("nolock_rdy0", req0_ready, 0);
            chk("nolock_mem_en", mem_en, 0);
        end
        locked = 1'b1;
        tick();
        chk("lock_edge1_rdy0", req0_ready, 0);
        tick();
        chk("lock_edge2_rdy0", req0_ready, 1);
        req0_valid = 1'b0;
        req0_we    = 1'b0;

        // Single read of addr 5
        req1_valid = 1'b1;
        req1_we    = 1'b0;
        req1_addr  = 10'h005;
        #1;
        chk("rd_rdy1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 10'h005);
        chk("rd_busy", busy, 1);
        tick();
        chk("rd_mem_en_pulse", mem_en, 0);
        tick();
        tick();
        chk("rd_rsp1_early", rsp1_valid, 0);
        tick();
        chk("rd_rsp1_valid", rsp1_valid, 1);
        chk("rd_rsp1_rdata", rsp1_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp0_valid", rsp0_valid, 0);
        tick();
        chk("rd_rsp1_pulse", rsp1_valid, 0);
        chk("rd_rsp1_hold", rsp1_rdata, 32'hDEAD_BEEF);
        chk("rd_busy_idle", busy, 0);

        // Contention: writes by req0 and reads by req1 to addr 0..3
        wi = 0;
        ri = 0;
        req0_we = 1'b1;
        req1_we = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                req0_valid = 1'b1;
                req1_valid = 1'b1;
                req0_addr  = 10'(wi);
                req0_wdata = 32'hA000_0000 + 32'(wi);
                req1_addr  = 10'(ri);
                #1;
                chk("cont_rdy0", req0_ready, (c % 2 == 0));
                chk("cont_rdy1", req1_ready, (c % 2 == 1));
            end else begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            tick();
            if (c < 8) begin
                chk("cont_mem_en", mem_en, 1);
                chk("cont_mem_we", mem_we, (c % 2 == 0));
                if (c % 2 == 0) begin
                    chk("cont_wr_addr", mem_addr, 32'(wi));
                    chk("cont_wr_data", mem_wdata, 32'hA000_0000 + 32'(wi));
                    wi++;
                end else begin
                    chk("cont_rd_addr", mem_addr, 32'(ri));
                    ri++;
                end
            end
            exp_rsp = (c >= 5) && (c % 2 == 1);
            chk("cont_rsp1_valid", rsp1_valid, exp_rsp);
            if (exp_rsp) begin
                chk("cont_rsp1_rdata", rsp1_rdata, 32'hA000_0000 + 32'((c - 5) / 2));
            end
            chk("cont_rsp0_valid", rsp0_valid, 0);
        end

        // Write 0x3FF then read it back the next cycle
        req0_valid = 1'b1;
        req0_we    = 1'b1;
        req0_addr  = 10'h3FF;
        req0_wdata = 32'h1234_5678;
        #1;
        chk("wr3ff_rdy0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_we    = 1'b0;
        req1_addr  = 10'h3FF;
        #1;
        chk("rd3ff_rdy1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        repeat (3) tick();
        chk("rd3ff_early", rsp1_valid, 0);
        tick();
        chk("rd3ff_valid", rsp1_valid, 1);
        chk("rd3ff_rdata", rsp1_rdata, 32'h1234_5678);

        // Reset one cycle after a read handshake
        req1_valid = 1'b1;
        req1_addr  = 10'h005;
        tick();
        req1_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_mem_wdata", mem_wdata, 0);
        chk("midrst_rsp1_rdata", rsp1_rdata, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_relock1", lock_ready_probe(), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_rsp1", rsp1_valid, 0);
            chk("midrst_no_rsp0", rsp0_valid, 0);
        end
        req1_valid = 1'b1;
        req1_addr  = 10'h005;
        #1;
        chk("postrst_rdy1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        repeat (3) tick();
        tick();
        chk("postrst_rsp1_valid", rsp1_valid, 1);
        chk("postrst_rsp1_rdata", rsp1_rdata, 32'hDEAD_BEEF);

        // Lock lost one cycle after a read handshake
        req1_valid = 1'b1;
        req1_addr  = 10'h3FF;
        #1;
        chk("ll_rdy1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        locked = 1'b0;
        tick();
        tick();
        req0_valid = 1'b1;
        req0_we    = 1'b1;
        req0_addr  = 10'h010;
        req0_wdata = 32'h5555_AAAA;
        #1;
        chk("ll_rdy0_gated", req0_ready, 0);
        tick();
        chk("ll_rsp1_valid", rsp1_valid, 1);
        chk("ll_rsp1_rdata", rsp1_rdata, 32'h1234_5678);
        chk("ll_rdy0_gated2", req0_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ll_rdy0_hold", req0_ready, 0);
            chk("ll_mem_en", mem_en, 0);
        end
        locked = 1'b1;
        tick();
        chk("relock_edge1", req0_ready, 0);
        tick();
        chk("relock_edge2", req0_ready, 1);
        req0_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // With no request present, a granted-looking ready would indicate a bad gate.
    function automatic logic lock_ready_probe();
        return req0_ready | req1_ready;
    endfunction

endmodule
